// File: rtl/bcd_word_addsub_if.sv
// Start/done handshake bundle for the digit-serial BCD word adder/subtractor.
// master: start, sub, A, B, Cin out; ready, done, S, Cout, invalid in. slave: mirror.
interface bcd_word_addsub_if #(
  parameter int DIGIT_NUM = 8
);
  logic                   start;
  logic                   sub;
  logic [4*DIGIT_NUM-1:0] A;
  logic [4*DIGIT_NUM-1:0] B;
  logic                   Cin;
  logic                   ready;
  logic                   done;
  logic [4*DIGIT_NUM-1:0] S;
  logic                   Cout;
  logic                   invalid;

  modport master (
    output start, sub, A, B, Cin,
    input  ready, done, S, Cout, invalid
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output ready, done, S, Cout, invalid
  );
endinterface

// File: rtl/bcd_word_addsub.sv
// Digit-serial packed-BCD add/subtract, DIGITS_PER_CYCLE digits per clock.
// Ports: clk, reset (sync, active-high), bus (slave: start/sub/A/B/Cin in,
// ready/done/S/Cout/invalid out). Optional macro: BCD_INPUT_CHECK_EN.
module bcd_word_addsub #(
  parameter int DIGIT_NUM        = 8,
  parameter int DIGITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  bcd_word_addsub_if.slave  bus
);

  localparam int N      = 4 * DIGIT_NUM;
  localparam int W      = 4 * DIGITS_PER_CYCLE;
  localparam int CHUNKS = DIGIT_NUM / DIGITS_PER_CYCLE;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            sub_q;
  logic            carry_q;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    s_q;
  logic            cout_q;
  logic            ready_q;
  logic            done_q;

  logic [W-1:0]    ca;
  logic [W-1:0]    cb;
  logic [W-1:0]    cs;
  logic            cc;
  logic            c;
  logic [3:0]      da;
  logic [3:0]      db;
  logic [4:0]      r;
  int unsigned     base;

  // One decimal digit: binary sum, then +6 correction when it exceeds 9.
  function automatic logic [4:0] dig_add(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [4:0] s;
    logic [3:0] t;
    s = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    t = s[3:0] + 4'd6;
    if (s > 5'd9)
      return {1'b1, t};
    else
      return {1'b0, s[3:0]};
  endfunction

  always_comb begin
    base = int'(cnt) * W;
    ca   = a_q[base +: W];
    cb   = b_q[base +: W];
  end

  // DPC digit adders chained; B is nine's-complemented in subtract mode.
  always_comb begin
    c  = carry_q;
    cs = '0;
    da = '0;
    db = '0;
    r  = '0;
    for (int i = 0; i < DIGITS_PER_CYCLE; i++) begin
      da = ca[4*i +: 4];
      db = cb[4*i +: 4];
      if (sub_q)
        db = 4'd9 - db;
      r  = dig_add(da, db, c);
      cs[4*i +: 4] = r[3:0];
      c  = r[4];
    end
    cc = c;
  end

`ifdef BCD_INPUT_CHECK_EN
  logic invalid_q;

  function automatic logic has_bad(input logic [N-1:0] v);
    for (int i = 0; i < DIGIT_NUM; i++)
      if (v[4*i +: 4] > 4'd9)
        return 1'b1;
    return 1'b0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      invalid_q <= 1'b0;
    else if (ready_q && bus.start)
      invalid_q <= has_bad(bus.A) | has_bad(bus.B);
  end

  assign bus.invalid = invalid_q;
`else
  assign bus.invalid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            sub_q   <= bus.sub;
            // Subtract borrow-in enters the chain inverted.
            carry_q <= bus.sub ? ~bus.Cin : bus.Cin;
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= RUN;
          end else begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        RUN: begin
          s_q[base +: W] <= cs;
          carry_q <= cc;
          cout_q  <= cc;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.S     = s_q;
  assign bus.Cout  = cout_q;

endmodule

// File: doc/bcd_word_addsub.md
# bcd_word_addsub

Digit-serial BCD word adder/subtractor that processes a multi-digit packed-BCD operand pair a configurable number of digits per clock. It replaces the fully combinational ripple BCD word adder in the arithmetic datapath wherever timing or area needs the carry chain cut into registered chunks. It adds subtract mode using nine's complement, and uses a start/done handshake toward the control FSM.

## Interface
- DIGIT_NUM, 8, number of BCD digits per operand (≥1)
- DIGITS_PER_CYCLE, 2, digits processed per clock; must divide DIGIT_NUM; equal to DIGIT_NUM gives single-chunk operation
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when `ready`=1
- sub  input  1  0 = add, 1 = subtract; sampled with start
- A  input  4*DIGIT_NUM  packed BCD operand, digit 0 in bits [3:0]; sampled with start
- B  input  4*DIGIT_NUM  packed BCD operand; sampled with start
- Cin  input  1  carry in (add) / borrow in (subtract); sampled with start
- ready  output  1  block can accept start
- done  output  1  one-cycle pulse: S/Cout valid
- S  output  4*DIGIT_NUM  packed BCD result
- Cout  output  1  add: decimal carry out; subtract: 1 = no borrow (result ≥ 0), 0 = borrow
- invalid  output  1  non-BCD digit (>9) seen in A or B (see Configuration)

## Operation
- CHUNKS = DIGIT_NUM / DIGITS_PER_CYCLE; chunk counter width ceil(log2(CHUNKS)), minimum 1.
- States: IDLE, RUN, DONE.
  - IDLE: ready=1. start → latch A, B, sub, Cin; carry register ← (sub ? ~Cin : Cin); counter ← 0; go to RUN.
  - RUN: ready=0. Each cycle, chunk `counter`, i.e. digits [counter*DPC +: DPC], passes through DPC chained BCD digit adders.
    - B digit replaced by 9−B when sub=1.
    - Result digits are written into the S register; carry register ← chunk carry out; counter++.
    - After chunk CHUNKS−1: go to DONE.
  - DONE: done=1, ready=1, Cout = final carry register. start here is accepted exactly as in IDLE and goes to RUN; otherwise go to IDLE.
- Digit adder: binary sum s = a+b+c (5 bits); if s>9 then digit = s+6 (low 4 bits), carry = 1; else digit = s, carry = 0.
- Subtract: S = A + nines(B) + ~Cin = A − B − Cin mod 10^DIGIT_NUM. Negative results appear in ten's-complement form with Cout=0.
- S and Cout hold their last value from DONE until the next chunk writes. S is updated chunk-by-chunk during RUN and is only valid when done=1.
- start while ready=0 is ignored and has no effect.

## Timing
- Reset values: state IDLE, ready=1, done=0, S=0, Cout=0, invalid=0, counter=0.
- start accepted on edge t: chunks processed on edges t+1 … t+CHUNKS. done=1 during the cycle following edge t+CHUNKS.
  - Latency start→done = CHUNKS+1 cycles.
  - Back-to-back starts (start held high) give throughput of one result per CHUNKS+1 cycles.
- reset asserted in any state: on that edge, return to IDLE with reset values. The partial result is discarded and done does not pulse.

## Configuration
- BCD_INPUT_CHECK_EN defined: on start acceptance, invalid ← 1 if any digit of A or B exceeds 9, else 0. It holds until the next accepted start or reset. The computation still runs and S is don't-care when invalid=1.
- Not defined: no check logic; invalid is tied to 0.

## Test plan
DIGIT_NUM=8, DIGITS_PER_CYCLE=2 unless stated.
- Add: A=99999999, B=00000001, Cin=0, sub=0 → done exactly 5 cycles after the start edge; S=00000000, Cout=1.
- Subtract: A=00000100, B=00000001, Cin=0, sub=1 → S=00000099, Cout=1. Then A=00000001, B=00000002 → S=99999999, Cout=0.
- Handshake: pulse start again 2 cycles after the first start with different operands → ignored, and the first result is unchanged. Hold start high through DONE with A=12345678, B=11111111 → the second op starts from DONE and returns S=23456789.
- Reset mid-op: assert reset on the 3rd RUN cycle → next cycle ready=1, S=0, Cout=0, and no done pulse.
- With BCD_INPUT_CHECK_EN: A=0000000A, B=0 → invalid=1 from the cycle after the start edge. Then valid operands → invalid=0. Without the macro, invalid stays 0.
- DIGITS_PER_CYCLE=8: A=50000000, B=50000000, Cin=1 → S=00000001, Cout=1, done 2 cycles after start.
